// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common-data-bus arbiter. Buffers completed results in a
//               2-entry queue per functional unit and broadcasts one per cycle
//               on a registered CDB. Define CDB_FIXED_PRIO_EN for fixed
//               lowest-index-first priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_rs_num,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_rs_num,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [NUM_FU-1:0]        cdb_grant
);

    localparam int c_PTR_W = $clog2(NUM_FU);

    logic [TAG_W-1:0]   r_tag   [NUM_FU][2];
    logic [DATA_W-1:0]  r_data  [NUM_FU][2];
    logic [1:0]         r_count [NUM_FU];
    logic [NUM_FU-1:0]  r_head;
    logic [NUM_FU-1:0]  r_tail;

    logic               r_cdb_valid;
    logic [TAG_W-1:0]   r_cdb_rs_num;
    logic [DATA_W-1:0]  r_cdb_data;
    logic [NUM_FU-1:0]  r_cdb_grant;

    logic [NUM_FU-1:0]  w_push;
    logic [NUM_FU-1:0]  w_pop;
    logic [NUM_FU-1:0]  w_cand;
    logic               w_found;
    logic [c_PTR_W-1:0] w_win;

    // Ready looks only at the registered count, never at this cycle's pop.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
            assign fu_ready[gi] = (r_count[gi] != 2'd2);
            assign w_cand[gi]   = (r_count[gi] != 2'd0);
            assign w_push[gi]   = fu_valid[gi] & fu_ready[gi] &
                                  (fu_rs_num[gi*TAG_W +: TAG_W] != '0);
            assign w_pop[gi]    = w_found & (w_win == c_PTR_W'(gi));
        end
    endgenerate

`ifdef CDB_FIXED_PRIO_EN
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_found = 1'b1;
                w_win   = c_PTR_W'(k);
            end
        end
    end
`else
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [c_PTR_W:0]   w_idx;

    // Search starts at the round-robin pointer and wraps modulo NUM_FU.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
            if (w_idx >= (c_PTR_W+1)'(NUM_FU)) begin
                w_idx = w_idx - (c_PTR_W+1)'(NUM_FU);
            end
            if (!w_found && w_cand[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_win == c_PTR_W'(NUM_FU - 1)) ? '0 : w_win + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_tag[i][0]  <= '0;
                r_tag[i][1]  <= '0;
                r_data[i][0] <= '0;
                r_data[i][1] <= '0;
                r_count[i]   <= 2'd0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rs_num <= '0;
            r_cdb_data   <= '0;
            r_cdb_grant  <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_tag[i][r_tail[i]]  <= fu_rs_num[i*TAG_W +: TAG_W];
                    r_data[i][r_tail[i]] <= fu_data[i*DATA_W +: DATA_W];
                    r_tail[i]            <= ~r_tail[i];
                end
                if (w_pop[i]) begin
                    r_head[i] <= ~r_head[i];
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + 2'd1;
                    2'b01:   r_count[i] <= r_count[i] - 2'd1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
            r_cdb_valid  <= w_found;
            r_cdb_rs_num <= w_found ? r_tag[w_win][r_head[w_win]]  : '0;
            r_cdb_data   <= w_found ? r_data[w_win][r_head[w_win]] : '0;
            r_cdb_grant  <= w_pop;
        end
    end

    assign cdb_valid  = r_cdb_valid;
    assign cdb_rs_num = r_cdb_rs_num;
    assign cdb_data   = r_cdb_data;
    assign cdb_grant  = r_cdb_grant;

endmodule
`default_nettype wire
